// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the word-to-UART packet transmitter.
// Packet length depends on the UART_TX_CHECKSUM_EN macro.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    START    = 3'd2,
    DATA     = 3'd3,
    STOP     = 3'd4,
    DONE     = 3'd5,
    WAIT_LOW = 3'd6
  } state_e;

  localparam int BITS_PER_FRAME = 32'sd10;

  // Sync byte, the data bytes and, optionally, the checksum byte.
  function automatic int pkt_bytes(input int data_bit);
`ifdef UART_TX_CHECKSUM_EN
    return data_bit / 32'sd8 + 32'sd2;
`else
    return data_bit / 32'sd8 + 32'sd1;
`endif
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick is high on the last cycle of every CLK_DIV-cycle
// window, counted from the most recent clear.
module uart_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;

  // Free-running modulo-CLK_DIV counter, held at zero while cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (cnt_r == TOP) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign tick = (cnt_r == TOP);

endmodule

// File: rtl/uart_word_tx.sv
// Serializes one FIFO word per go assertion as a UART packet: sync byte,
// data bytes MSB first, then an XOR checksum byte when UART_TX_CHECKSUM_EN is defined.
module uart_word_tx
  import uart_tx_pkg::*;
#(
  parameter int         DATA_BIT  = 32,
  parameter int         CLK_DIV   = 434,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [DATA_BIT-1:0] data_in,
  output logic                done,
  output logic                tx,
  output logic                busy
);

  localparam int NB        = DATA_BIT / 8;
  localparam int PKT_BYTES = pkt_bytes(DATA_BIT);
  localparam int BCW       = $clog2(PKT_BYTES + 1);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(PKT_BYTES - 1);

  state_e              state_r, state_s;
  logic [2:0]          bit_cnt_r, bit_cnt_s;
  logic [BCW-1:0]      byte_cnt_r, byte_cnt_s;
  logic [DATA_BIT-1:0] word_r, word_s;
  logic [7:0]          shreg_r, shreg_s;
  logic                tx_r, tx_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;
  logic                tick_s;
  logic                clear_s;

`ifdef UART_TX_CHECKSUM_EN
  localparam logic [BCW-1:0] NB_IDX = BCW'(NB);
  logic [7:0] csum_r, csum_s;

  function automatic logic [7:0] xor_csum(input logic [DATA_BIT-1:0] w);
    logic [7:0] acc;
    acc = SYNC_BYTE;
    for (int i = 0; i < NB; i++) begin
      acc = acc ^ w[i*8 +: 8];
    end
    return acc;
  endfunction
`endif

  // The baud timer only runs while a frame is on the line.
  assign clear_s = (state_r != START) && (state_r != DATA) && (state_r != STOP);

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (clear_s),
    .tick  (tick_s)
  );

  // Next-state and datapath updates for the packet sequencer.
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    byte_cnt_s = byte_cnt_r;
    word_s     = word_r;
    shreg_s    = shreg_r;
`ifdef UART_TX_CHECKSUM_EN
    csum_s     = csum_r;
`endif
    case (state_r)
      IDLE: begin
        if (go) state_s = SETTLE;
        else    state_s = IDLE;
      end
      SETTLE: begin
        word_s     = data_in;
        shreg_s    = SYNC_BYTE;
        bit_cnt_s  = 3'd0;
        byte_cnt_s = '0;
`ifdef UART_TX_CHECKSUM_EN
        csum_s     = xor_csum(data_in);
`endif
        state_s    = START;
      end
      START: begin
        if (tick_s) begin
          state_s   = DATA;
          bit_cnt_s = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          shreg_s = {1'b0, shreg_r[7:1]};
          if (bit_cnt_r == 3'd7) state_s = STOP;
          else                   bit_cnt_s = bit_cnt_r + 3'd1;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (!tick_s) begin
          state_s = STOP;
        end else if (byte_cnt_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s    = START;
          bit_cnt_s  = 3'd0;
          byte_cnt_s = byte_cnt_r + BCW'(1'b1);
          // Data bytes leave the top of the word; once exhausted, the checksum follows.
`ifdef UART_TX_CHECKSUM_EN
          if (byte_cnt_r < NB_IDX) begin
            shreg_s = word_r[DATA_BIT-1 -: 8];
            word_s  = {word_r[DATA_BIT-9:0], 8'h00};
          end else begin
            shreg_s = csum_r;
          end
`else
          shreg_s = word_r[DATA_BIT-1 -: 8];
          word_s  = {word_r[DATA_BIT-9:0], 8'h00};
`endif
        end
      end
      DONE:     state_s = WAIT_LOW;
      WAIT_LOW: begin
        if (!go) state_s = IDLE;
        else     state_s = WAIT_LOW;
      end
      default:  state_s = IDLE;
    endcase
  end

  // Outputs decoded from the next state so they can be registered alongside it.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[0];
      default: tx_s = 1'b1;
    endcase
    busy_s = (state_s != IDLE) && (state_s != WAIT_LOW);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= '0;
      word_r     <= '0;
      shreg_r    <= 8'h00;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      csum_r     <= 8'h00;
`endif
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      byte_cnt_r <= byte_cnt_s;
      word_r     <= word_s;
      shreg_r    <= shreg_s;
      tx_r       <= tx_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
`ifdef UART_TX_CHECKSUM_EN
      csum_r     <= csum_s;
`endif
    end
  end

  assign tx   = tx_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: expected line activity is rebuilt from
// the packet's byte list as a flat bit queue; honours UART_TX_CHECKSUM_EN.
module tb_uart_word_tx;
  import uart_tx_pkg::*;

  localparam int DB = 32;
  localparam int CD = 4;
  localparam int NBYTES = pkt_bytes(DB);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic        done, tx, busy;

  int vectors = 0;
  int errs = 0;
  int gcnt = 0;
  int drop_at = 0;
  logic exp_bits[$];

  always #5 clk = ~clk;

  uart_word_tx #(.DATA_BIT(DB), .CLK_DIV(CD), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .go(go), .data_in(data_in),
    .done(done), .tx(tx), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: packet bytes -> framed bit stream (start, 8 bits LSB first, stop).
  task automatic build_exp(input logic [31:0] w);
    logic [7:0] b[$];
    logic [7:0] c;
    b = {};
    b.push_back(8'hA5);
    c = 8'hA5;
    for (int i = DB/8 - 1; i >= 0; i--) begin
      b.push_back(w[i*8 +: 8]);
      c = c ^ w[i*8 +: 8];
    end
`ifdef UART_TX_CHECKSUM_EN
    b.push_back(c);
`endif
    exp_bits = {};
    foreach (b[k]) begin
      exp_bits.push_back(1'b0);
      for (int j = 0; j < 8; j++) exp_bits.push_back(b[k][j]);
      exp_bits.push_back(1'b1);
    end
  endtask

  task automatic step();
    @(negedge clk);
    gcnt++;
    if (gcnt == drop_at) go = 1'b0;
  endtask

  // One packet: go raised, go dropped after `drop` cycles, quiet check while held.
  task automatic packet(input logic [31:0] w, input int drop, input int hold_after);
    int   lat;
    logic ok;
    build_exp(w);
    step();
    go = 1'b1; data_in = $urandom; gcnt = 0; drop_at = drop;
    step();
    check("settle_busy", busy, 32'd1);
    check("settle_tx", tx, 32'd1);
    data_in = w;
    step();
    data_in = $urandom;
    lat = 2;
    while (tx !== 1'b0 && lat < 40) begin step(); lat++; end
    check("start_latency", lat, 32'd2);
    if (tx === 1'b0) begin
      for (int j = 0; j < exp_bits.size(); j++) begin
        ok = 1'b1;
        for (int s = 0; s < CD; s++) begin
          if (j != 0 || s != 0) step();
          if (tx !== exp_bits[j] || done !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check($sformatf("bit%0d_w%08h", j, w), ok, 32'd1);
      end
      step();
      check("done_pulse", done, 32'd1);
      check("done_busy", busy, 32'd1);
      step();
      check("done_clear", done, 32'd0);
      check("busy_clear", busy, 32'd0);
    end
    if (go) begin
      ok = 1'b1;
      for (int i = 0; i < hold_after; i++) begin
        step();
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 1'b0;
      end
      check("held_go_quiet", ok, 32'd1);
      go = 1'b0;
      step();
    end
  endtask

  initial begin
    logic ok;
    logic [31:0] w;

    // Reset held for three cycles.
    reset = 1'b1; go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_tx", tx, 32'd1);
      check("rst_done", done, 32'd0);
      check("rst_busy", busy, 32'd0);
    end
    reset = 1'b0;

    // Basic packet with go dropped mid-packet.
    packet(32'h12345678, 60, 0);

    // Held go: no second packet until go falls and rises again.
    packet($urandom, 1000000, 500);

    // Reset during the third byte abandons the packet.
    w = $urandom;
    step();
    go = 1'b1; data_in = w; gcnt = 0; drop_at = 3;
    repeat (2 + 2 * BITS_PER_FRAME * CD + 5) step();
    check("mid_busy", busy, 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_tx", tx, 32'd1);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_done", done, 32'd0);
    reset = 1'b0;
    ok = 1'b1;
    repeat (NBYTES * BITS_PER_FRAME * CD + 20) begin
      step();
      if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check("abandoned_quiet", ok, 32'd1);
    packet(32'h12345678, 1, 0);

    // Back-to-back single-cycle go pulses.
    packet(32'hFFFFFFFF, 1, 0);
    packet(32'h00000000, 1, 0);

    // Random words, random go release point.
    for (int n = 0; n < 6; n++) begin
      packet($urandom, int'($urandom_range(1, 250)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
